// File: rtl/ss_slot_if.sv
// ss_slot_if: signal bundle between the OSD/core side and ss_slot_ctrl.
//   save_req/load_req : OSD save/load request levels, bit n = slot n
//   ss_busy           : core is executing a save/restore
//   ss_do_save/ss_do_restore : single-cycle commands to the core
//   ss_addr/ss_slot   : DDR base address and index of the active slot
//   busy/done/error   : controller status (done/error are one-cycle pulses)
//   slot_valid        : slot n holds a completed save
// master = OSD/core side, slave = the controller.
interface ss_slot_if #(
  parameter int unsigned SLOTS = 4
);
  logic [SLOTS-1:0] save_req;
  logic [SLOTS-1:0] load_req;
  logic             ss_busy;
  logic             ss_do_save;
  logic             ss_do_restore;
  logic [31:0]      ss_addr;
  logic [1:0]       ss_slot;
  logic             busy;
  logic             done;
  logic             error;
  logic [SLOTS-1:0] slot_valid;

  modport master (
    output save_req, load_req, ss_busy,
    input  ss_do_save, ss_do_restore, ss_addr, ss_slot,
           busy, done, error, slot_valid
  );

  modport slave (
    input  save_req, load_req, ss_busy,
    output ss_do_save, ss_do_restore, ss_addr, ss_slot,
           busy, done, error, slot_valid
  );
endinterface

// File: rtl/ss_slot_ctrl.sv
// ss_slot_ctrl: save-state slot controller between the OSD Save/Load State
// bits and the core's save-state ports. Level requests are edge-detected and
// turned into one-cycle ss_do_save/ss_do_restore commands; the command is
// tracked through the core's ss_busy handshake with start/done timeouts, and
// a per-slot valid bit records completed saves.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : ss_slot_if.slave (requests, core handshake, status outputs)
module ss_slot_ctrl #(
  parameter int unsigned SLOTS         = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h3E000000,
  parameter logic [31:0] SLOT_SIZE     = 32'h00200000,
  parameter logic [15:0] START_TIMEOUT = 16'd1024,
  parameter logic [23:0] DONE_TIMEOUT  = 24'hFFFFFF
) (
  input  logic      clk,
  input  logic      reset,
  ss_slot_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    OK,
    FAIL
  } state_t;

  // Counter value in the last allowed cycle of each wait state.
  localparam logic [23:0] START_LAST = 24'(START_TIMEOUT) - 24'd1;
  localparam logic [23:0] DONE_LAST  = DONE_TIMEOUT - 24'd1;

  state_t           state_q, state_d;
  logic [23:0]      cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [31:0]      addr_q, addr_d;
  logic             op_save_q, op_save_d;
  logic             reject_q, reject_d;
  logic [SLOTS-1:0] valid_q, valid_d;

  logic [SLOTS-1:0] save_prev, load_prev;
  logic [SLOTS-1:0] save_rise, load_rise;
  logic [1:0]       win_idx;
  logic             win_found;

  assign save_rise = bus.save_req & ~save_prev;
  assign load_rise = bus.load_req & ~load_prev;

  // Any save rise beats any load rise; lowest index wins within a class.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    if (|save_rise) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (save_rise[i] && !win_found) begin
          win_idx   = 2'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (load_rise[i] && !win_found) begin
          win_idx   = 2'(i);
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    addr_d    = addr_q;
    op_save_d = op_save_q;
    reject_d  = 1'b0;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          slot_d    = win_idx;
          addr_d    = BASE_ADDR + 32'(win_idx) * SLOT_SIZE;
          op_save_d = |save_rise;
          // Loading an empty slot is rejected without bothering the core.
          if (!(|save_rise) && !valid_q[win_idx]) begin
            reject_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.ss_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == START_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.ss_busy) begin
          state_d = OK;
        end else if (cnt_q == DONE_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      OK: begin
        if (op_save_q) valid_d[slot_q] = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        // A save that did not complete may have partially overwritten the slot.
        if (op_save_q) valid_d[slot_q] = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Edge-detect history also loads during reset, so a level held through
    // reset release does not look like a new request.
    save_prev <= bus.save_req;
    load_prev <= bus.load_req;
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      slot_q    <= '0;
      addr_q    <= '0;
      op_save_q <= 1'b0;
      reject_q  <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      addr_q    <= addr_d;
      op_save_q <= op_save_d;
      reject_q  <= reject_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.ss_do_save    = (state_q == ISSUE) && op_save_q;
  assign bus.ss_do_restore = (state_q == ISSUE) && !op_save_q;
  assign bus.ss_addr       = addr_q;
  assign bus.ss_slot       = slot_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == OK);
  assign bus.error         = (state_q == FAIL) || reject_q;
  assign bus.slot_valid    = valid_q;

endmodule

// File: tb/tb_ss_slot_ctrl.sv
// Bench for ss_slot_ctrl: directed scenarios followed by random commands,
// checked against a transaction-level model of slot validity and timing.
module tb_ss_slot_ctrl;
  localparam int T = 40;
  localparam int D = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ss_slot_if #(.SLOTS(4)) bus ();

  ss_slot_ctrl #(
    .SLOTS(4),
    .BASE_ADDR(32'h3E000000),
    .SLOT_SIZE(32'h00200000),
    .START_TIMEOUT(16'd40),
    .DONE_TIMEOUT(24'd100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [3:0] mvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  // Core's ss_busy level in cycle c after the command pulse (pulse = cycle 0).
  function automatic logic bz(input int c, input int s, input int h);
    return (c >= s) && (c < s + h);
  endfunction

  // One request; s/h describe the core's ss_busy window relative to the pulse.
  task automatic cmd(input logic [3:0] sv, input logic [3:0] ld, input int s,
                     input int h, input bit inject);
    int w, r, f, endc;
    bit is_save, rej, ok;
    logic [31:0] ea;
    is_save = (sv != 4'b0);
    w = is_save ? lowest(sv) : lowest(ld);
    ea = 32'h3E000000 + 32'(w) * 32'h00200000;
    rej = !is_save && !mvalid[w];
    bus.save_req = sv;
    bus.load_req = ld;
    tick();
    chk("slot", 32'(bus.ss_slot), 32'(w));
    chk("addr", bus.ss_addr, ea);
    chk1("busy_issue", bus.busy, !rej);
    chk1("err_issue", bus.error, rej);
    chk1("do_save", bus.ss_do_save, is_save && !rej);
    chk1("do_restore", bus.ss_do_restore, !is_save && !rej);
    chk1("done_issue", bus.done, 1'b0);
    bus.save_req = '0;
    bus.load_req = '0;
    if (rej) begin
      tick();
      chk1("err_once", bus.error, 1'b0);
      chk1("busy_rej", bus.busy, 1'b0);
      chk1("restore_rej", bus.ss_do_restore, 1'b0);
      chk("valid_rej", 32'(bus.slot_valid), 32'(mvalid));
      return;
    end
    // Expected end cycle: start window covers cycles 1..T, done window D cycles.
    r = -1;
    for (int c = 1; c <= T; c++) if (r < 0 && bz(c, s, h)) r = c;
    if (r < 0) begin
      endc = T + 1;
      ok = 0;
    end else begin
      f = -1;
      for (int c = r + 1; c <= r + D; c++) if (f < 0 && !bz(c, s, h)) f = c;
      if (f < 0) begin
        endc = r + 1 + D;
        ok = 0;
      end else begin
        endc = f + 1;
        ok = 1;
      end
    end
    for (int c = 0; c < endc; c++) begin
      bus.ss_busy = bz(c, s, h);
      if (inject && c == 2) bus.save_req = 4'b0001;
      tick();
      chk1("no_save", bus.ss_do_save, 1'b0);
      chk1("no_restore", bus.ss_do_restore, 1'b0);
      chk1("busy_run", bus.busy, 1'b1);
      chk1("done", bus.done, ok && (c + 1 == endc));
      chk1("error", bus.error, !ok && (c + 1 == endc));
      chk("valid_run", 32'(bus.slot_valid), 32'(mvalid));
      chk("addr_run", bus.ss_addr, ea);
    end
    if (is_save) mvalid[w] = ok;
    bus.ss_busy = 1'b0;
    bus.save_req = '0;
    tick();
    chk1("busy_end", bus.busy, 1'b0);
    chk1("done_end", bus.done, 1'b0);
    chk1("error_end", bus.error, 1'b0);
    chk1("save_end", bus.ss_do_save, 1'b0);
    chk("valid_end", 32'(bus.slot_valid), 32'(mvalid));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sv, ld;
    int s, h, sel;
    reset = 1'b1;
    bus.save_req = 4'b0010;
    bus.load_req = '0;
    bus.ss_busy = 1'b0;
    mvalid = '0;
    repeat (3) tick();
    chk("rst_addr", bus.ss_addr, 32'h0);
    chk("rst_slot", 32'(bus.ss_slot), 32'h0);
    chk("rst_valid", 32'(bus.slot_valid), 32'h0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_error", bus.error, 1'b0);
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk1("held_no_save", bus.ss_do_save, 1'b0);
      chk1("held_no_busy", bus.busy, 1'b0);
    end
    bus.save_req = '0;
    tick();

    cmd(4'b0010, 4'b0000, 2, 3, 0);
    cmd(4'b1000, 4'b0000, 5, 100, 0);
    cmd(4'b0000, 4'b0100, 1, 3, 0);
    cmd(4'b0100, 4'b0000, 1, 4, 0);
    cmd(4'b0000, 4'b0100, 3, 6, 0);
    cmd(4'b0100, 4'b0001, 2, 5, 1);
    cmd(4'b0001, 4'b0000, 1, 2, 0);
    cmd(4'b0001, 4'b0000, 0, 0, 0);
    cmd(4'b0010, 4'b0000, 2, 1000, 0);

    // Reset while the core is busy.
    bus.save_req = 4'b1000;
    tick();
    chk1("mid_do_save", bus.ss_do_save, 1'b1);
    bus.save_req = '0;
    bus.ss_busy = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk1("mid_busy", bus.busy, 1'b0);
    chk("mid_valid", 32'(bus.slot_valid), 32'h0);
    chk1("mid_done", bus.done, 1'b0);
    chk1("mid_error", bus.error, 1'b0);
    reset = 1'b0;
    bus.ss_busy = 1'b0;
    mvalid = '0;
    tick();
    chk1("post_busy", bus.busy, 1'b0);
    chk1("post_error", bus.error, 1'b0);
    cmd(4'b0010, 4'b0000, 1, 3, 0);

    for (int i = 0; i < 40; i++) begin
      sv = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ld = 4'($urandom_range(0, 15));
      if (sv == 4'b0 && ld == 4'b0) ld = 4'b0001;
      s = $urandom_range(0, 6);
      sel = $urandom_range(0, 9);
      if (sel == 0) h = 0;
      else if (sel == 1) h = 1000;
      else h = $urandom_range(1, 20);
      cmd(sv, ld, s, h, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ss_slot_ctrl.md
Name: ss_slot_ctrl

Overview:
- Save-state slot controller between the hps_io OSD status bits (Save/Load State 1-4) and the F2 core's save-state ports.
- Converts level-held OSD request bits into single-cycle save/restore commands.
- Computes the DDR base address of the selected slot and tracks command completion through the core's busy handshake.
- Tracks a per-slot valid bit and reports done/error to the OSD/LED logic.

Parameters:
- SLOTS, 4, number of save-state slots (request vector width).
- BASE_ADDR, 32'h3E000000, DDR byte address of slot 0.
- SLOT_SIZE, 32'h00200000, byte stride between slots.
- START_TIMEOUT, 16'd1024, cycles allowed between command pulse and ss_busy rising.
- DONE_TIMEOUT, 24'hFFFFFF, cycles allowed for ss_busy to fall once high.

Ports:
- clk  in  1  system clock (clk_sys); the only clock.
- reset  in  1  synchronous, active-high reset.
- save_req  in  SLOTS  OSD save-request levels, bit n = slot n.
- load_req  in  SLOTS  OSD load-request levels, bit n = slot n.
- ss_busy  in  1  core is executing a save/restore.
- ss_do_save  out  1  single-cycle save command to core.
- ss_do_restore  out  1  single-cycle restore command to core.
- ss_addr  out  32  DDR base address of the active slot.
- ss_slot  out  2  index of the active slot.
- busy  out  1  controller not idle.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on rejection or timeout.
- slot_valid  out  SLOTS  slot n holds a completed save.

Behaviour:
- Reset values:
  - All outputs 0: ss_addr = 0, ss_slot = 0, slot_valid = 0, busy = 0.
  - FSM goes to IDLE and counters clear.
  - During reset, the edge-detect registers load the current save_req/load_req. A bit held high through reset release produces no command.
- Edge detection:
  - rise = req & ~prev, registered every cycle in every state.
  - Rises seen outside IDLE are dropped and not queued.
- IDLE arbitration when any rise is present:
  - Any save rise beats any load rise.
  - Within a class, the lowest slot index wins. All other rises in that cycle are dropped.
  - Latch ss_slot = winner and ss_addr = BASE_ADDR + winner*SLOT_SIZE (32-bit, wrap modulo 2^32).
  - Latch op = save or restore.
  - Load of a slot with slot_valid = 0: error pulses next cycle, no command issued, FSM stays in IDLE. ss_slot/ss_addr still update.
  - Otherwise go to ISSUE; busy = 1 from the cycle after the winning rise.
- ISSUE (1 cycle):
  - Assert ss_do_save or ss_do_restore for exactly one cycle.
  - ss_addr and ss_slot are already stable and stay stable until back in IDLE.
  - Clear the timeout counter and go to WAIT_START.
- WAIT_START:
  - ss_busy = 1 → WAIT_DONE with counter cleared.
  - Else the counter increments. When it reaches START_TIMEOUT → FAIL.
  - ss_busy sampled high in the ISSUE cycle is ignored. Only WAIT_START sampling counts.
- WAIT_DONE:
  - ss_busy = 0 → OK.
  - Else the counter increments. When it reaches DONE_TIMEOUT → FAIL.
- OK (1 cycle):
  - done = 1.
  - If op = save, set slot_valid[ss_slot].
  - Go to IDLE.
- FAIL (1 cycle):
  - error = 1.
  - If op = save, clear slot_valid[ss_slot], since a partial write corrupts the slot.
  - Go to IDLE.
- busy is 1 in ISSUE, WAIT_START, WAIT_DONE, OK and FAIL; 0 in IDLE.
- Minimum successful command latency: rise → ss_do_* 1 cycle; ss_busy rise + fall → done 1 cycle after ss_busy falls is sampled.
- Reset mid-operation: returns to IDLE immediately, no done/error pulse, slot_valid cleared.
- slot_valid bits for other slots never change during a command.
- Restore does not modify slot_valid.

Test Plan:
- Reset release with save_req=4'b0010 held → no ss_do_save. Drop save_req[1], raise it again → ss_do_save 1 cycle, ss_slot=1, ss_addr=32'h3E200000.
- Save slot 3: core raises ss_busy 5 cycles after the pulse and holds it 100 cycles → done pulse once, slot_valid=4'b1000, busy low one cycle after done.
- load_req[2] rises with slot_valid[2]=0 → error pulse, no ss_do_restore, busy stays 0. After a successful save to slot 2, load_req[2] → ss_do_restore, ss_addr=32'h3E400000, done, slot_valid unchanged.
- Same-cycle rises save_req=4'b0100 and load_req=4'b0001 → save to slot 2 only. New rise on save_req[0] while busy → ignored, no second command.
- ss_busy never rises after the pulse → error exactly START_TIMEOUT cycles into WAIT_START. A prior valid save slot is cleared. With ss_busy stuck high and DONE_TIMEOUT=100 → error after 100 cycles in WAIT_DONE.
- reset asserted in WAIT_DONE → next cycle busy=0, slot_valid=0, no done/error. Following save request operates normally.
